// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks prefixes and modifiers, translates makes to ASCII
// and queues characters for the LC-3 KBSR/KBDR registers.
module ps2_key_decoder #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_rdy,
    input  logic [8:0] cmd,
    input  logic       error,
    input  logic       kb_rd,
    input  logic       ovf_clr,
    output logic       kb_rdy,
    output logic [7:0] kb_data,
    output logic       kb_ovf,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // {hit, letter, base char, shifted char}; letters carry their upper case as shifted form
    function automatic logic [17:0] key_rom(input logic [7:0] code);
        logic [17:0] r;
        case (code)
            8'h1C: r = {2'b11, 8'h61, 8'h41};  8'h32: r = {2'b11, 8'h62, 8'h42};
            8'h21: r = {2'b11, 8'h63, 8'h43};  8'h23: r = {2'b11, 8'h64, 8'h44};
            8'h24: r = {2'b11, 8'h65, 8'h45};  8'h2B: r = {2'b11, 8'h66, 8'h46};
            8'h34: r = {2'b11, 8'h67, 8'h47};  8'h33: r = {2'b11, 8'h68, 8'h48};
            8'h43: r = {2'b11, 8'h69, 8'h49};  8'h3B: r = {2'b11, 8'h6A, 8'h4A};
            8'h42: r = {2'b11, 8'h6B, 8'h4B};  8'h4B: r = {2'b11, 8'h6C, 8'h4C};
            8'h3A: r = {2'b11, 8'h6D, 8'h4D};  8'h31: r = {2'b11, 8'h6E, 8'h4E};
            8'h44: r = {2'b11, 8'h6F, 8'h4F};  8'h4D: r = {2'b11, 8'h70, 8'h50};
            8'h15: r = {2'b11, 8'h71, 8'h51};  8'h2D: r = {2'b11, 8'h72, 8'h52};
            8'h1B: r = {2'b11, 8'h73, 8'h53};  8'h2C: r = {2'b11, 8'h74, 8'h54};
            8'h3C: r = {2'b11, 8'h75, 8'h55};  8'h2A: r = {2'b11, 8'h76, 8'h56};
            8'h1D: r = {2'b11, 8'h77, 8'h57};  8'h22: r = {2'b11, 8'h78, 8'h58};
            8'h35: r = {2'b11, 8'h79, 8'h59};  8'h1A: r = {2'b11, 8'h7A, 8'h5A};
            8'h16: r = {2'b10, 8'h31, 8'h21};  8'h1E: r = {2'b10, 8'h32, 8'h40};
            8'h26: r = {2'b10, 8'h33, 8'h23};  8'h25: r = {2'b10, 8'h34, 8'h24};
            8'h2E: r = {2'b10, 8'h35, 8'h25};  8'h36: r = {2'b10, 8'h36, 8'h5E};
            8'h3D: r = {2'b10, 8'h37, 8'h26};  8'h3E: r = {2'b10, 8'h38, 8'h2A};
            8'h46: r = {2'b10, 8'h39, 8'h28};  8'h45: r = {2'b10, 8'h30, 8'h29};
            8'h4E: r = {2'b10, 8'h2D, 8'h5F};  8'h55: r = {2'b10, 8'h3D, 8'h2B};
            8'h54: r = {2'b10, 8'h5B, 8'h7B};  8'h5B: r = {2'b10, 8'h5D, 8'h7D};
            8'h4C: r = {2'b10, 8'h3B, 8'h3A};  8'h52: r = {2'b10, 8'h27, 8'h22};
            8'h0E: r = {2'b10, 8'h60, 8'h7E};  8'h41: r = {2'b10, 8'h2C, 8'h3C};
            8'h49: r = {2'b10, 8'h2E, 8'h3E};  8'h4A: r = {2'b10, 8'h2F, 8'h3F};
            8'h5D: r = {2'b10, 8'h5C, 8'h7C};  8'h29: r = {2'b10, 8'h20, 8'h20};
            8'h5A: r = {2'b10, 8'h0A, 8'h0A};  8'h66: r = {2'b10, 8'h08, 8'h08};
            8'h0D: r = {2'b10, 8'h09, 8'h09};  8'h76: r = {2'b10, 8'h1B, 8'h1B};
            default: r = 18'h00000;
        endcase
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic             lshift_r, rshift_r, lctrl_r, rctrl_r, caps_r;
    logic             lshift_nxt_s, rshift_nxt_s, lctrl_nxt_s, rctrl_nxt_s, caps_nxt_s;
    logic             key_vld_s, key_ext_s, key_brk_s;
    logic             char_vld_s, pend_vld_r;
    logic [7:0]       char_s, pend_char_r, err_cnt_r;
    logic [7:0]       code_s, rom_base_s, rom_shift_s;
    logic             rom_hit_s, rom_letter_s, shift_s, ctrl_s, is_f0_s, is_e0_s;
    logic             unused_parity_s;
    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic             fifo_empty_s, fifo_full_s, do_push_s, do_pop_s, ovf_set_s;
    logic             kb_rdy_r, kb_ovf_r;
    logic [7:0]       kb_data_r, kb_data_nxt_s;

    assign code_s          = cmd[7:0];
    assign unused_parity_s = cmd[8];
    assign is_f0_s         = (code_s == 8'hF0);
    assign is_e0_s         = (code_s == 8'hE0);
    assign {rom_hit_s, rom_letter_s, rom_base_s, rom_shift_s} = key_rom(code_s);
    assign shift_s         = lshift_r | rshift_r;
    assign ctrl_s          = lctrl_r | rctrl_r;

    // Prefix parser: decides which bytes are keys and whether they are extended/break
    always_comb begin
        state_nxt_s = state_r;
        key_vld_s   = 1'b0;
        key_ext_s   = 1'b0;
        key_brk_s   = 1'b0;
        if (cmd_rdy && error) begin
            state_nxt_s = ST_IDLE;
        end else if (cmd_rdy) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_f0_s) state_nxt_s = ST_BRK;
                    else if (is_e0_s) state_nxt_s = ST_EXT;
                    else key_vld_s = 1'b1;
                end
                ST_EXT: begin
                    if (is_f0_s) state_nxt_s = ST_EXT_BRK;
                    else if (is_e0_s) state_nxt_s = ST_EXT;
                    else begin key_vld_s = 1'b1; key_ext_s = 1'b1; state_nxt_s = ST_IDLE; end
                end
                ST_BRK: begin
                    if (is_e0_s) state_nxt_s = ST_EXT;
                    else if (is_f0_s) state_nxt_s = ST_BRK;
                    else begin key_vld_s = 1'b1; key_brk_s = 1'b1; state_nxt_s = ST_IDLE; end
                end
                ST_EXT_BRK: begin
                    if (is_e0_s) state_nxt_s = ST_EXT;
                    else if (is_f0_s) state_nxt_s = ST_EXT_BRK;
                    else begin
                        key_vld_s   = 1'b1;
                        key_ext_s   = 1'b1;
                        key_brk_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Key action: modifier updates or character translation
    always_comb begin
        lshift_nxt_s = lshift_r;
        rshift_nxt_s = rshift_r;
        lctrl_nxt_s  = lctrl_r;
        rctrl_nxt_s  = rctrl_r;
        caps_nxt_s   = caps_r;
        char_vld_s   = 1'b0;
        char_s       = 8'h00;
        if (key_vld_s) begin
            if (!key_ext_s && code_s == 8'h12) lshift_nxt_s = ~key_brk_s;
            else if (!key_ext_s && code_s == 8'h59) rshift_nxt_s = ~key_brk_s;
            else if (key_ext_s && code_s == 8'h14) rctrl_nxt_s = ~key_brk_s;
            else if (code_s == 8'h14) lctrl_nxt_s = ~key_brk_s;
            else if (!key_ext_s && code_s == 8'h58) caps_nxt_s = caps_r ^ ~key_brk_s;
            else if (!key_ext_s && !key_brk_s && rom_hit_s) begin
                if (rom_letter_s) begin
                    char_vld_s = 1'b1;
                    if (ctrl_s) char_s = rom_shift_s & 8'h1F;
                    else if (shift_s ^ caps_r) char_s = rom_shift_s;
                    else char_s = rom_base_s;
                end else if (!ctrl_s) begin
                    char_vld_s = 1'b1;
                    char_s     = shift_s ? rom_shift_s : rom_base_s;
                end else begin
                    char_vld_s = 1'b0;
                end
            end else begin
                char_vld_s = 1'b0;
            end
        end else begin
            char_vld_s = 1'b0;
        end
    end

    // Parser, modifier, pending-char and error-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            lshift_r    <= 1'b0;
            rshift_r    <= 1'b0;
            lctrl_r     <= 1'b0;
            rctrl_r     <= 1'b0;
            caps_r      <= 1'b0;
            pend_vld_r  <= 1'b0;
            pend_char_r <= 8'h00;
            err_cnt_r   <= 8'h00;
        end else begin
            state_r     <= state_nxt_s;
            lshift_r    <= lshift_nxt_s;
            rshift_r    <= rshift_nxt_s;
            lctrl_r     <= lctrl_nxt_s;
            rctrl_r     <= rctrl_nxt_s;
            caps_r      <= caps_nxt_s;
            pend_vld_r  <= char_vld_s;
            pend_char_r <= char_s;
            if (cmd_rdy && error && err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'h01;
            else err_cnt_r <= err_cnt_r;
        end
    end

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign do_pop_s     = kb_rd & ~fifo_empty_s;
    assign do_push_s    = pend_vld_r & (~fifo_full_s | do_pop_s);
    assign ovf_set_s    = pend_vld_r & fifo_full_s & ~do_pop_s;
    assign wr_ptr_nxt_s = wr_ptr_r + {{PTR_W{1'b0}}, do_push_s};
    assign rd_ptr_nxt_s = rd_ptr_r + {{PTR_W{1'b0}}, do_pop_s};

    // Head after this edge; bypass the char being written when it lands at the new head
    always_comb begin
        kb_data_nxt_s = 8'h00;
        if (wr_ptr_nxt_s == rd_ptr_nxt_s) kb_data_nxt_s = 8'h00;
        else if (do_push_s && rd_ptr_nxt_s[PTR_W-1:0] == wr_ptr_r[PTR_W-1:0]) kb_data_nxt_s = pend_char_r;
        else kb_data_nxt_s = mem_r[rd_ptr_nxt_s[PTR_W-1:0]];
    end

    // Character FIFO with registered head/ready and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            kb_rdy_r  <= 1'b0;
            kb_data_r <= 8'h00;
            kb_ovf_r  <= 1'b0;
        end else begin
            if (do_push_s) mem_r[wr_ptr_r[PTR_W-1:0]] <= pend_char_r;
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            kb_rdy_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            kb_data_r <= kb_data_nxt_s;
            if (ovf_set_s) kb_ovf_r <= 1'b1;
            else if (ovf_clr) kb_ovf_r <= 1'b0;
            else kb_ovf_r <= kb_ovf_r;
        end
    end

    assign kb_rdy  = kb_rdy_r;
    assign kb_data = kb_data_r;
    assign kb_ovf  = kb_ovf_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random keystroke
// streams, compared every cycle against a queue-based reference model.
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_rdy = 1'b0;
    logic [8:0] cmd = 9'h000;
    logic       error = 1'b0;
    logic       kb_rd = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       kb_rdy;
    logic [7:0] kb_data;
    logic       kb_ovf;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .error(error),
        .kb_rd(kb_rd), .ovf_clr(ovf_clr), .kb_rdy(kb_rdy), .kb_data(kb_data),
        .kb_ovf(kb_ovf), .err_cnt(err_cnt)
    );

    // US layout tables: letter i is ASCII 'a'+i; digits/punctuation as character strings
    logic [7:0] let_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] sym_code [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                  8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h0E, 8'h41,
                                  8'h49, 8'h4A, 8'h5D};
    string      sym_base = "1234567890-=[];'`,./\\";
    string      sym_shft = "!@#$%^&*()_+{}:\"~<>?|";
    logic [7:0] nam_code [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] nam_char [5] = '{8'h20, 8'h0A, 8'h08, 8'h09, 8'h1B};
    logic [7:0] mod_code [4] = '{8'h12, 8'h59, 8'h14, 8'h58};
    logic [7:0] oth_code [4] = '{8'h75, 8'h05, 8'h7A, 8'h6B};

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf, m_pv, m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_caps;
    logic [7:0] m_pc;
    int         m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_ovf = 0; m_pv = 0; m_pc = 8'h00; m_err = 0;
        m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_lc = 0; m_rc = 0; m_caps = 0;
    endfunction

    function automatic void m_key(input logic [7:0] code, input bit ext, input bit brk);
        bit sh = m_ls | m_rs;
        bit ct = m_lc | m_rc;
        if (!ext && code == 8'h12) m_ls = !brk;
        else if (!ext && code == 8'h59) m_rs = !brk;
        else if (code == 8'h14) begin
            if (ext) m_rc = !brk;
            else m_lc = !brk;
        end else if (!ext && code == 8'h58) begin
            if (!brk) m_caps = !m_caps;
        end else if (!ext && !brk) begin
            for (int i = 0; i < 26; i++)
                if (let_code[i] == code) begin
                    m_pv = 1;
                    if (ct) m_pc = (8'h41 + 8'(i)) & 8'h1F;
                    else if (sh ^ m_caps) m_pc = 8'h41 + 8'(i);
                    else m_pc = 8'h61 + 8'(i);
                end
            for (int i = 0; i < 21; i++)
                if (sym_code[i] == code && !ct) begin
                    m_pv = 1;
                    m_pc = sh ? sym_shft[i] : sym_base[i];
                end
            for (int i = 0; i < 5; i++)
                if (nam_code[i] == code && !ct) begin
                    m_pv = 1;
                    m_pc = nam_char[i];
                end
        end
    endfunction

    function automatic void m_byte(input logic [7:0] b, input bit e);
        if (e) begin
            m_ext = 0; m_brk = 0;
            if (m_err < 255) m_err++;
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) begin
            m_ext = 1; m_brk = 0;
        end else begin
            m_key(b, m_ext, m_brk);
            m_ext = 0; m_brk = 0;
        end
    endfunction

    // One clock edge of the model: last edge's char enters the queue, then this byte decodes
    function automatic void m_step(input bit v, input logic [7:0] b, input bit e,
                                   input bit rd, input bit clr);
        bit pop  = rd && (mq.size() > 0);
        bit push = 0;
        bit oset = 0;
        if (m_pv) begin
            if (mq.size() < DEPTH || pop) push = 1;
            else oset = 1;
        end
        if (clr) m_ovf = 0;
        if (oset) m_ovf = 1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(m_pc);
        m_pv = 0;
        if (v) m_byte(b, e);
    endfunction

    task automatic tick(input bit v, input logic [7:0] b, input bit e, input bit rd, input bit clr);
        cmd_rdy = v; cmd = {1'($urandom_range(0, 1)), b}; error = e; kb_rd = rd; ovf_clr = clr;
        @(posedge clk);
        m_step(v, b, e, rd, clr);
        @(negedge clk);
        cmd_rdy = 1'b0; error = 1'b0; kb_rd = 1'b0; ovf_clr = 1'b0;
        check("kb_rdy", kb_rdy, (mq.size() != 0));
        check("kb_data", kb_data, (mq.size() != 0) ? mq[0] : 8'h00);
        check("kb_ovf", kb_ovf, m_ovf);
        check("err_cnt", err_cnt, m_err);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_head(input string tag, input logic [7:0] val);
        check(tag, {kb_rdy, kb_data}, {1'b1, val});
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_outs", {kb_rdy, kb_data, kb_ovf, err_cnt}, 18'h00000);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", {kb_rdy, kb_data, kb_ovf, err_cnt}, 18'h00000);
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        do_reset();

        // Plain make, latency and break suppression
        send(8'h1C);
        check("lat_k", kb_rdy, 1'b0);
        send(8'hF0);
        check("lat_k1", kb_rdy, 1'b1);
        send(8'h1C);
        idle(2);
        expect_head("plain_a", 8'h61);
        check("one_char", kb_rdy, 1'b0);

        // Error drops the prefix and counts; counter saturates
        tick(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        send(8'h1C);
        idle(2);
        check("err_one", err_cnt, 8'h01);
        expect_head("err_drop", 8'h61);
        repeat (256) tick(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        check("err_sat", err_cnt, 8'hFF);

        // Shift and caps
        foreach (let_code[i]) if (i == 0) begin
            send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        end
        idle(2);
        expect_head("shift_A", 8'h41);
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); idle(2);
        expect_head("caps_A", 8'h41);
        send(8'h12); send(8'h1C); idle(2);
        expect_head("caps_shift_a", 8'h61);
        send(8'h12); send(8'h16); idle(2);
        expect_head("shift_1", 8'h21);
        send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58); idle(2);
        check("mods_silent", kb_rdy, 1'b0);

        // Right ctrl via extended prefix, then extended keys that emit nothing
        send(8'hE0); send(8'h14); send(8'h21);
        send(8'hE0); send(8'hF0); send(8'h14); send(8'h21); idle(2);
        expect_head("ctrl_c", 8'h03);
        expect_head("plain_c", 8'h63);
        send(8'hE0); send(8'h75); idle(2);
        check("arrow", kb_rdy, 1'b0);

        // FIFO full, overflow, coincident pop+write, clear, set-over-clear
        repeat (9) send(8'h1C);
        idle(2);
        check("ovf_set", kb_ovf, 1'b1);
        send(8'h1C);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_sticky", kb_ovf, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", kb_ovf, 1'b0);
        send(8'h1C);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("no_ovf", kb_ovf, 1'b0);
        send(8'h1C);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("set_wins", kb_ovf, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (DEPTH) expect_head("fifo_a", 8'h61);
        check("fifo_empty", kb_rdy, 1'b0);

        // Reset in the middle of a break sequence with a char queued
        send(8'h1C);
        send(8'hF0);
        @(negedge clk);
        do_reset();
        send(8'h1C);
        idle(2);
        expect_head("rst_seq", 8'h61);
        check("rst_one", kb_rdy, 1'b0);

        // Random keystroke events with random reads, clears and parity errors
        repeat (300) begin
            int          cat = $urandom_range(0, 9);
            logic [7:0]  code;
            bit          ext = ($urandom_range(0, 4) == 0);
            bit          brk = ($urandom_range(0, 2) == 0);
            logic [7:0]  seq[$];
            if (cat < 4) code = let_code[$urandom_range(0, 25)];
            else if (cat < 6) code = sym_code[$urandom_range(0, 20)];
            else if (cat == 6) code = nam_code[$urandom_range(0, 4)];
            else if (cat < 9) code = mod_code[$urandom_range(0, 3)];
            else code = oth_code[$urandom_range(0, 3)];
            if (ext) seq.push_back(8'hE0);
            if (brk) seq.push_back(8'hF0);
            seq.push_back(code);
            foreach (seq[i])
                tick(1'b1, seq[i], ($urandom_range(0, 24) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
            repeat ($urandom_range(0, 2))
                tick(1'b0, 8'h00, 1'b0, ($urandom_range(0, 1) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
